// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux: N input channels merged onto one registered output.
interface stream_mux_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic [SW-1:0]      out_sel;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );
endinterface

// File: rtl/stream_mux.sv
// Round-robin N:1 stream multiplexer with one registered output stage.
// Define STREAM_MUX_PACKET_LOCK_EN to hold the grant on a channel until its in_last beat.
module stream_mux #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    stream_mux_if.slave  bus
);

    logic [SW-1:0]    ptr_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [SW-1:0]    out_sel_q;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    logic             lock_q;
`endif

    logic [SW-1:0]    grant_s;
    logic             grant_vld_s;
    logic             stage_free_s;
    logic [N-1:0]     in_ready_s;
    logic             accept_s;

    // Arbitration: first requester after ptr, wrapping round to ptr itself.
    always_comb begin
        grant_s      = ptr_q;
        grant_vld_s  = 1'b0;
        stage_free_s = !out_valid_q || bus.out_ready;
`ifdef STREAM_MUX_PACKET_LOCK_EN
        if (lock_q) begin
            grant_s     = ptr_q;
            grant_vld_s = 1'b1;
        end else begin
`else
        begin
`endif
            // Walk from the farthest candidate down so the nearest one wins.
            for (int k = N; k >= 1; k--) begin
                if (bus.in_valid[(int'(ptr_q) + k) % N]) begin
                    grant_s     = SW'((int'(ptr_q) + k) % N);
                    grant_vld_s = 1'b1;
                end else begin
                    grant_s     = grant_s;
                end
            end
        end
    end

    // One-hot ready towards the granted channel only when the stage can take a beat.
    always_comb begin
        in_ready_s = {N{1'b0}};
        if (grant_vld_s && stage_free_s && !rst) begin
            in_ready_s = {{(N-1){1'b0}}, 1'b1} << grant_s;
        end else begin
            in_ready_s = {N{1'b0}};
        end
        accept_s = |(in_ready_s & bus.in_valid);
    end

    // Output stage, round-robin pointer and packet lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= SW'(N - 1);
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= {SW{1'b0}};
`ifdef STREAM_MUX_PACKET_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else if (accept_s) begin
            ptr_q       <= grant_s;
            out_data_q  <= bus.in_data[grant_s*WIDTH +: WIDTH];
            out_valid_q <= 1'b1;
            out_last_q  <= bus.in_last[grant_s];
            out_sel_q   <= grant_s;
`ifdef STREAM_MUX_PACKET_LOCK_EN
            lock_q      <= !bus.in_last[grant_s];
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux (N=4, WIDTH=8): expected beats are queued by the
// driver and popped by an independent monitor on every output handshake.
module tb_stream_mux;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SW    = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [SW+WIDTH:0] exp_q[$];

    stream_mux_if #(.N(N), .WIDTH(WIDTH), .SW(SW)) bus ();

    stream_mux #(.N(N), .WIDTH(WIDTH), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [SW+WIDTH:0] ex(input int s, input logic [WIDTH-1:0] d, input logic l);
        return {SW'(s), d, l};
    endfunction

    // Monitor: every output handshake must match the oldest queued expectation.
    initial begin
        logic [SW+WIDTH:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat act=%0h exp=none",
                             {bus.out_sel, bus.out_data, bus.out_last});
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({bus.out_sel, bus.out_data, bus.out_last}), 32'(e));
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst           = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b1111;
        bus.in_data   = 32'hC3C2C1C0;
        bus.out_ready = 1'b1;

        // Reset: two edges with every channel requesting.
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("first_grant_ch0", 32'(bus.in_ready), 32'b0001);

        // Round robin, one beat per cycle.
        for (int i = 0; i < 8; i++) exp_q.push_back(ex(i % 4, 8'hC0 + 8'(i % 4), 1'b1));
        repeat (8) begin
            @(negedge clk);
            chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 4'b0000;
        drain();

        // Backpressure with a held 0xA5 beat, then same-cycle replace.
        @(negedge clk);
        bus.in_data[7:0] = 8'hA5;
        bus.in_valid     = 4'b0001;
        bus.out_ready    = 1'b0;
        exp_q.push_back(ex(0, 8'hA5, 1'b1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_data", 32'(bus.out_data), 32'hA5);
            chk("bp_in_ready", 32'(bus.in_ready), 32'b0000);
            bus.in_valid = 4'b0010;
        end
        bus.out_ready = 1'b1;
        exp_q.push_back(ex(1, 8'hC1, 1'b1));
        @(negedge clk);
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_sel", 32'(bus.out_sel), 32'd1);
        bus.in_valid     = 4'b0000;
        bus.in_data[7:0] = 8'hC0;
        drain();

        // Sparse requests on channels 1 and 3 starting from ptr=3.
        @(negedge clk);
        bus.in_valid = 4'b1000;
        exp_q.push_back(ex(3, 8'hC3, 1'b1));
        @(negedge clk);
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) exp_q.push_back(ex((i % 2 == 0) ? 1 : 3, (i % 2 == 0) ? 8'hC1 : 8'hC3, 1'b1));
        repeat (4) begin
            @(negedge clk);
            chk("sparse_no_0_2", 32'(bus.in_ready & 4'b0101), 32'd0);
        end
        bus.in_valid = 4'b0000;
        drain();

        // Packet test: move ptr to 1, then channel 2 sends a 3-beat packet against channel 0.
        @(negedge clk);
        bus.in_valid = 4'b0010;
        exp_q.push_back(ex(1, 8'hC1, 1'b1));
        @(negedge clk);
        bus.in_valid = 4'b0101;
        bus.in_last  = 4'b1011;
`ifdef STREAM_MUX_PACKET_LOCK_EN
        exp_q.push_back(ex(2, 8'hC2, 1'b0));
        exp_q.push_back(ex(2, 8'hC2, 1'b0));
        exp_q.push_back(ex(2, 8'hC2, 1'b1));
        exp_q.push_back(ex(0, 8'hC0, 1'b1));
        @(negedge clk);
        chk("lock_ready_ch2", 32'(bus.in_ready), 32'b0100);
        @(negedge clk);
        chk("lock_ready_ch2", 32'(bus.in_ready), 32'b0100);
        bus.in_last = 4'b1111;
        @(negedge clk);
        bus.in_valid = 4'b0001;
        @(negedge clk);
`else
        exp_q.push_back(ex(2, 8'hC2, 1'b0));
        exp_q.push_back(ex(0, 8'hC0, 1'b1));
        exp_q.push_back(ex(2, 8'hC2, 1'b0));
        exp_q.push_back(ex(0, 8'hC0, 1'b1));
        repeat (4) @(negedge clk);
`endif
        bus.in_valid = 4'b0000;
        bus.in_last  = 4'b1111;
        drain();

        // Reset while a beat is held: nothing survives, channel 0 regains priority.
        @(negedge clk);
        bus.in_valid  = 4'b0001;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 4'b0000;
        chk("held_before_rst", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_out", 32'({bus.out_valid, bus.out_data, bus.out_last, bus.out_sel}), 32'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0101;
        exp_q.push_back(ex(0, 8'hC0, 1'b1));
        @(negedge clk);
        bus.in_valid = 4'b0000;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
